// File: rtl/fu_muldiv_sequencer.sv
// Multi-cycle unsigned 32x32 multiply / 32/32 divide engine that drives the
// combinational function unit once per bit (shift-add and restoring divide).
module fu_muldiv_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] FS_PASS = 5'b00000,
    parameter logic [4:0] FS_ADD  = 5'b00010,
    parameter logic [4:0] FS_SUB  = 5'b00101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic [4:0]       fu_fs,
    output logic [4:0]       fu_sh,
    input  logic [WIDTH-1:0] fu_f,
    input  logic             fu_c
);

    // state  | meaning
    // IDLE   | waiting for start, ready high
    // STEP   | one function-unit operation per operand bit
    // DONE   | results settled; done pulses once, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state_q;
    logic             op_q;
    logic [WIDTH-1:0] m_q, p_q, q_q;
    logic [CW-1:0]    count_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;

    logic [WIDTH-1:0] p_d, q_d, shifted;
    logic             qbit;

    always_comb begin
        shifted = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
        // A set P[31] means the shifted remainder is >= 2^32 > M, so the subtract always fits.
        qbit    = p_q[WIDTH-1] | ~fu_c;
        fu_a    = '0;
        fu_b    = '0;
        fu_fs   = FS_PASS;
        p_d     = p_q;
        q_d     = q_q;
        if (state_q == S_STEP) begin
            fu_b = m_q;
            if (op_q) begin
                fu_a  = shifted;
                fu_fs = FS_SUB;
                p_d   = qbit ? fu_f : shifted;
                q_d   = {q_q[WIDTH-2:0], qbit};
            end else begin
                fu_a  = p_q;
                fu_fs = q_q[0] ? FS_ADD : FS_PASS;
                p_d   = {fu_c, fu_f[WIDTH-1:1]};
                q_d   = {fu_f[0], q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            m_q      <= '0;
            p_q      <= '0;
            q_q      <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        m_q     <= opb;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        p_q     <= '0;
                        q_q     <= opa;
                        if (op && (opb == '0)) begin
                            res_lo_q <= '1;
                            res_hi_q <= opa;
                            dbz_q    <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    p_q     <= p_d;
                    q_q     <= q_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        res_hi_q <= p_d;
                        res_lo_q <= q_d;
                        dbz_q    <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle raises done; the second retires to IDLE.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result_hi   = res_hi_q;
    assign result_lo   = res_lo_q;
    assign fu_sh       = 5'd0;

endmodule

// File: tb/tb_fu_muldiv_sequencer.sv
// Bench for fu_muldiv_sequencer: behavioural function unit plus a plain
// arithmetic reference for products, quotients and remainders.
module tb_fu_muldiv_sequencer;

    localparam logic [4:0] FS_PASS = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b00010;
    localparam logic [4:0] FS_SUB  = 5'b00101;

    logic        clk = 1'b0;
    logic        rst_n, start, op;
    logic [31:0] opa, opb;
    logic        ready, busy, done, div_by_zero;
    logic [31:0] result_hi, result_lo;
    logic [31:0] fu_a, fu_b, fu_f;
    logic [4:0]  fu_fs, fu_sh;
    logic        fu_c;
    logic [32:0] fu_sum;

    int checks   = 0;
    int failures = 0;

    fu_muldiv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_fs       (fu_fs),
        .fu_sh       (fu_sh),
        .fu_f        (fu_f),
        .fu_c        (fu_c)
    );

    always #5 clk = ~clk;

    // Combinational function unit: only transfer, add and subtract are needed.
    always_comb begin
        case (fu_fs)
            FS_ADD:  fu_sum = {1'b0, fu_a} + {1'b0, fu_b};
            FS_SUB:  fu_sum = {1'b0, fu_a} - {1'b0, fu_b};
            default: fu_sum = {1'b0, fu_a};
        endcase
        fu_f = fu_sum[31:0];
        fu_c = fu_sum[32];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input string tag);
        logic [63:0] prod;
        logic [31:0] exp_hi, exp_lo;
        logic        exp_dbz;
        int          exp_lat, n;
        bit          got;
        if (!o) begin
            prod    = 64'(a) * 64'(b);
            exp_hi  = prod[63:32];
            exp_lo  = prod[31:0];
            exp_dbz = 1'b0;
            exp_lat = 34;
        end else if (b == 0) begin
            exp_hi  = a;
            exp_lo  = 32'hFFFFFFFF;
            exp_dbz = 1'b1;
            exp_lat = 2;
        end else begin
            exp_hi  = a % b;
            exp_lo  = a / b;
            exp_dbz = 1'b0;
            exp_lat = 34;
        end
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; opa = $urandom; opb = $urandom;
        n = 0;
        got = 0;
        while (!got && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done) got = 1;
            else begin
                if (n == 2 && exp_lat == 34) chk({tag, "/ready_mid"}, {ready, busy}, 2'b01);
                start = inject && (n == 5);
            end
        end
        start = 1'b0;
        chk({tag, "/done_seen"}, got, 1);
        if (got) begin
            chk({tag, "/latency"}, n + 1, exp_lat);
            chk({tag, "/busy_at_done"}, {busy, ready}, 2'b10);
            chk({tag, "/hi"}, result_hi, exp_hi);
            chk({tag, "/lo"}, result_lo, exp_lo);
            chk({tag, "/dbz"}, div_by_zero, exp_dbz);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "/after_done"}, {done, busy, ready}, 3'b001);
            chk({tag, "/hold_lo"}, result_lo, exp_lo);
        end
    endtask

    initial begin
        bit          seen_done;
        logic [31:0] ra, rb;
        logic        ro;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/flags", {ready, busy, done, div_by_zero}, 4'b1000);
        chk("reset/result", {result_hi, result_lo}, 64'd0);
        chk("reset/fu", {fu_a, fu_b, fu_fs, fu_sh}, 74'd0);
        rst_n = 1'b1;

        run_op(1'b0, 32'd7, 32'd6, 0, "mul7x6");
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulmax");
        run_op(1'b1, 32'd100, 32'd7, 0, "div100_7");
        run_op(1'b1, 32'd5, 32'd9, 0, "div5_9");
        run_op(1'b1, 32'hFFFFFFFF, 32'h80000001, 0, "div_ovf");
        run_op(1'b1, 32'd1234, 32'd0, 0, "div_zero");
        run_op(1'b1, 32'd5, 32'd9, 0, "dbz_clear");
        run_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 1, "mul_inject");
        run_op(1'b1, 32'hDEADBEEF, 32'h00001234, 1, "div_inject");

        // Reset mid-operation: outputs clear at once and no done follows.
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst/flags", {ready, busy, done, div_by_zero}, 4'b1000);
        chk("midrst/result", {result_hi, result_lo}, 64'd0);
        chk("midrst/fu", {fu_a, fu_b, fu_fs}, 69'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        chk("midrst/no_done", seen_done, 0);
        run_op(1'b0, 32'd3, 32'd3, 0, "mul3x3");

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                2:       begin rb = $urandom; ra = $urandom_range(0, 1000); end
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, i % 5 == 0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
